// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: read-mode selectors
// and a parameter sanity helper used at elaboration time.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // True when value is a power of two and at least 2.
    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// The array has no reset; occupancy is tracked entirely by the controller.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the write word on the rising edge when the controller accepts it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO controller with occupancy count, full/empty and
// almost-full/almost-empty flags, sticky overflow/underflow errors, and a
// selectable standard (registered) or first-word-fall-through read mode.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       rd_en,
    input  logic                       err_clr,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [CW-1:0] PTR_ONE = CW'(1);
    localparam bit            IS_FWFT = (FWFT == FIFO_MODE_FWFT);

    // Reject illegal configurations while elaborating.
    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_flags: DEPTH must be a power of two and >= 2");
    end
    if (AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_flags: AF_THRESH must not exceed DEPTH");
    end
    if (AE_THRESH >= DEPTH) begin : g_bad_ae
        $error("sync_fifo_flags: AE_THRESH must be below DEPTH");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
        $error("sync_fifo_flags: FWFT must be 0 or 1");
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CW-1:0]         wr_ptr;
    logic [CW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] dout_q;

    assign count        = wr_ptr - rd_ptr;
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A full FIFO refuses writes even if a read frees a slot in the same
    // cycle; an empty FIFO refuses reads even if a write lands concurrently.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (din),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    // Advance the pointers on accepted operations only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Output register: in standard mode it captures the head on an accepted
    // read; in FWFT mode it shadows the live head so the last word stays
    // visible once the FIFO drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (IS_FWFT ? !empty : rd_acc) begin
            dout_q <= rdata;
        end
    end

    assign dout = (IS_FWFT && !empty) ? rdata : dout_q;

    // Sticky error flags; a new error event takes priority over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a standard-mode and an FWFT-mode
// instance (DEPTH=4, AF_THRESH=3, AE_THRESH=1) share one stimulus stream.
module tb_sync_fifo_flags;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] din;
    logic       rd_en;
    logic       err_clr;

    logic [7:0] s_dout, f_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [2:0] s_count, f_count;

    int n_assert = 0;
    int n_fail   = 0;

    sync_fifo_flags #(
        .DATA_WIDTH (8), .DEPTH (4), .FWFT (0), .AF_THRESH (3), .AE_THRESH (1)
    ) u_std (
        .clk (clk), .rst_n (rst_n), .wr_en (wr_en), .din (din), .rd_en (rd_en),
        .err_clr (err_clr), .dout (s_dout), .full (s_full), .empty (s_empty),
        .almost_full (s_af), .almost_empty (s_ae), .count (s_count),
        .overflow (s_ovf), .underflow (s_unf)
    );

    sync_fifo_flags #(
        .DATA_WIDTH (8), .DEPTH (4), .FWFT (1), .AF_THRESH (3), .AE_THRESH (1)
    ) u_fwft (
        .clk (clk), .rst_n (rst_n), .wr_en (wr_en), .din (din), .rd_en (rd_en),
        .err_clr (err_clr), .dout (f_dout), .full (f_full), .empty (f_empty),
        .almost_full (f_af), .almost_empty (f_ae), .count (f_count),
        .overflow (f_ovf), .underflow (f_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; returns 1 time unit after the rising edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        wr_en   = w;
        din     = d;
        rd_en   = r;
        err_clr = c;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    logic [7:0] exp_s [6];
    logic [7:0] exp_f [6];

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; din = 8'h00; rd_en = 1'b0; err_clr = 1'b0;
        exp_s = '{8'h66, 8'h77, 8'h80, 8'h81, 8'h82, 8'h83};
        exp_f = '{8'h77, 8'h80, 8'h81, 8'h82, 8'h83, 8'h84};
        #2;
        // Reset state
        chk("rst_empty", s_empty, 1);  chk("rst_full", s_full, 0);
        chk("rst_count", s_count, 0);  chk("rst_ae", s_ae, 1);
        chk("rst_af", s_af, 0);        chk("rst_dout", s_dout, 0);
        chk("rst_ovf", s_ovf, 0);      chk("rst_unf", s_unf, 0);
        chk("rst_fdout", f_dout, 0);   chk("rst_fempty", f_empty, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // FWFT: a single write shows up without a read request
        cyc(1, 8'hA5, 0, 0);
        chk("fwft_dout_a5", f_dout, 8'hA5);  chk("fwft_empty0", f_empty, 0);
        chk("fwft_count1", f_count, 1);      chk("std_dout_hold0", s_dout, 0);
        cyc(0, 8'h00, 1, 0);
        chk("fwft_empty1", f_empty, 1);      chk("fwft_dout_keep", f_dout, 8'hA5);
        chk("std_dout_a5", s_dout, 8'hA5);   chk("std_empty1", s_empty, 1);

        // Fill to full, then overflow
        cyc(1, 8'h11, 0, 0);
        chk("w1_count", s_count, 1); chk("w1_ae", s_ae, 1); chk("w1_af", s_af, 0);
        chk("w1_fdout", f_dout, 8'h11);
        cyc(1, 8'h22, 0, 0);
        chk("w2_count", s_count, 2); chk("w2_ae", s_ae, 0); chk("w2_af", s_af, 0);
        cyc(1, 8'h33, 0, 0);
        chk("w3_count", s_count, 3); chk("w3_af", s_af, 1); chk("w3_full", s_full, 0);
        cyc(1, 8'h44, 0, 0);
        chk("w4_count", s_count, 4); chk("w4_full", s_full, 1); chk("w4_af", s_af, 1);
        chk("w4_ovf", s_ovf, 0);
        cyc(1, 8'h55, 0, 0);
        chk("w5_count", s_count, 4); chk("w5_full", s_full, 1); chk("w5_ovf", s_ovf, 1);
        chk("w5_fovf", f_ovf, 1);    chk("w5_fdout", f_dout, 8'h11);
        cyc(0, 8'h00, 0, 1);
        chk("ovf_clr", s_ovf, 0);    chk("ovf_clr_cnt", s_count, 4);

        // Drain: data order, flags, underflow
        cyc(0, 8'h00, 1, 0);
        chk("r1_dout", s_dout, 8'h11); chk("r1_count", s_count, 3); chk("r1_full", s_full, 0);
        chk("r1_fdout", f_dout, 8'h22);
        cyc(0, 8'h00, 1, 0);
        chk("r2_dout", s_dout, 8'h22); chk("r2_fdout", f_dout, 8'h33);
        cyc(0, 8'h00, 1, 0);
        chk("r3_dout", s_dout, 8'h33); chk("r3_ae", s_ae, 1); chk("r3_count", s_count, 1);
        chk("r3_fdout", f_dout, 8'h44);
        cyc(0, 8'h00, 1, 0);
        chk("r4_dout", s_dout, 8'h44); chk("r4_empty", s_empty, 1); chk("r4_unf", s_unf, 0);
        chk("r4_fdout", f_dout, 8'h44);
        cyc(0, 8'h00, 1, 0);
        chk("r5_unf", s_unf, 1);       chk("r5_dout", s_dout, 8'h44);
        chk("r5_fdout", f_dout, 8'h44); chk("r5_funf", f_unf, 1);
        cyc(0, 8'h00, 1, 1);
        chk("unf_set_wins", s_unf, 1);
        cyc(0, 8'h00, 0, 1);
        chk("unf_clr", s_unf, 0);

        // Empty: read rejected while concurrent write is accepted
        cyc(1, 8'h66, 1, 0);
        chk("ew_count", s_count, 1);   chk("ew_unf", s_unf, 1);
        chk("ew_sdout", s_dout, 8'h44); chk("ew_fdout", f_dout, 8'h66);
        cyc(0, 8'h00, 0, 1);
        chk("ew_unf_clr", s_unf, 0);

        // Steady state at count 2 across pointer wrap
        cyc(1, 8'h77, 0, 0);
        chk("c2_count", s_count, 2);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 8'h80 + 8'(i), 1, 0);
            chk($sformatf("wr_rd_dout%0d", i), s_dout, exp_s[i]);
            chk($sformatf("wr_rd_fdout%0d", i), f_dout, exp_f[i]);
            chk($sformatf("wr_rd_count%0d", i), s_count, 2);
        end

        // Full: concurrent read accepted, write rejected
        cyc(1, 8'h90, 0, 0);
        cyc(1, 8'h91, 0, 0);
        chk("f_full", s_full, 1);
        cyc(1, 8'h92, 1, 0);
        chk("fwr_count", s_count, 3); chk("fwr_ovf", s_ovf, 1);
        chk("fwr_dout", s_dout, 8'h84); chk("fwr_fdout", f_dout, 8'h85);
        chk("fwr_full", s_full, 0);
        cyc(0, 8'h00, 0, 1);
        chk("fwr_ovf_clr", s_ovf, 0);

        // Reset mid-burst at count 3 with a sticky error pending
        cyc(1, 8'hA0, 0, 0);
        cyc(1, 8'hA1, 0, 0);
        cyc(0, 8'h00, 1, 0);
        chk("pre_rst_count", s_count, 3); chk("pre_rst_ovf", s_ovf, 1);
        chk("pre_rst_dout", s_dout, 8'h85);
        wr_en = 1'b1; din = 8'hC3; rd_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_empty", s_empty, 1); chk("mrst_count", s_count, 0);
        chk("mrst_dout", s_dout, 0);   chk("mrst_ovf", s_ovf, 0);
        chk("mrst_full", s_full, 0);   chk("mrst_af", s_af, 0);
        chk("mrst_ae", s_ae, 1);       chk("mrst_fdout", f_dout, 0);
        chk("mrst_fempty", f_empty, 1);
        @(negedge clk);
        rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);

        // Resume after reset
        cyc(1, 8'hB7, 0, 0);
        chk("post_count", s_count, 1); chk("post_fdout", f_dout, 8'hB7);
        cyc(0, 8'h00, 1, 0);
        chk("post_dout", s_dout, 8'hB7); chk("post_empty", s_empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
